// File: rtl/tgfx_pkg.sv
// rtl/tgfx_pkg.sv - shared types and constants for the TurboGrafx ROM loader
package tgfx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_ACK   = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

    localparam logic [4:0]  SGX_INDEX  = 5'd2;

    // 16-byte rows where the Populous title string may sit
    localparam logic [11:0] POP_ROW_A  = 12'h212;
    localparam logic [11:0] POP_ROW_B  = 12'h1F2;

    localparam logic [15:0] POP_SIG_6  = 16'h4F50;
    localparam logic [15:0] POP_SIG_8  = 16'h5550;
    localparam logic [15:0] POP_SIG_10 = 16'h4F4C;
    localparam logic [15:0] POP_SIG_12 = 16'h5355;

    // {checked, expected word} for a byte offset within a signature row
    function automatic logic [16:0] pop_sig(input logic [3:0] off);
        case (off)
            4'd6:    pop_sig = {1'b1, POP_SIG_6};
            4'd8:    pop_sig = {1'b1, POP_SIG_8};
            4'd10:   pop_sig = {1'b1, POP_SIG_10};
            4'd12:   pop_sig = {1'b1, POP_SIG_12};
            default: pop_sig = 17'd0;
        endcase
    endfunction

endpackage

// File: rtl/tgfx_rom_loader_bit_rev8.sv
// rtl/tgfx_rom_loader_bit_rev8.sv - combinational bit reversal of one byte
module bit_rev8 (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = {din[0], din[1], din[2], din[3], din[4], din[5], din[6], din[7]};

endmodule

// File: rtl/tgfx_rom_loader.sv
// rtl/tgfx_rom_loader.sv - HPS ROM download sequencer with toggle-handshake writes
module tgfx_rom_loader
    import tgfx_pkg::*;
#(
    parameter int AW = 24
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [15:0]   ioctl_dout,
    output logic          ioctl_wait,
    input  logic          swap,
    output logic [AW-1:0] romwr_a,
    output logic [15:0]   romwr_d,
    output logic          rom_wr,
    input  logic          dd_wrack,
    input  logic          sd_wrack,
    output logic          sgx,
    output logic [1:0]    populous,
    output logic          hdr,
    output logic [AW-17:0] rom_sz,
    output logic          ovf
);

    // Power-up values; image state deliberately survives a core reset
    loader_state_e state_q     = ST_IDLE;
    logic          dl_q        = 1'b0;
    logic          rom_wr_q    = 1'b0;
    logic          wait_q      = 1'b0;
    logic [AW-1:0] romwr_a_q   = '0;
    logic [15:0]   romwr_d_q   = 16'd0;
    logic          sgx_q       = 1'b0;
    logic [1:0]    populous_q  = 2'b11;
    logic          hdr_q       = 1'b0;
    logic          ovf_q       = 1'b0;
    logic          fall_pend_q = 1'b0;

    loader_state_e state_d;
    logic          rom_wr_d, wait_d, sgx_d, hdr_d, ovf_d, fall_pend_d;
    logic [AW-1:0] romwr_a_d, addr_inc;
    logic [15:0]   romwr_d_d;
    logic [1:0]    populous_d;

    logic          dl_rise, dl_fall, acked, pop_row;
    logic [7:0]    rev_hi, rev_lo;
    logic [15:0]   wr_data;
    logic [16:0]   sig;
    logic          unused_idx;

    bit_rev8 u_rev_hi (.din(ioctl_dout[15:8]), .dout(rev_hi));
    bit_rev8 u_rev_lo (.din(ioctl_dout[7:0]),  .dout(rev_lo));

    assign dl_rise    = ioctl_download & ~dl_q;
    assign dl_fall    = ~ioctl_download & dl_q;
    assign acked      = (dd_wrack == rom_wr_q) && (sd_wrack == rom_wr_q);
    assign wr_data    = swap ? {rev_hi, rev_lo} : ioctl_dout;
    assign sig        = pop_sig(romwr_a_q[3:0]);
    assign pop_row    = (romwr_a_q[AW-1:4] == (AW-4)'(POP_ROW_A)) ||
                        (romwr_a_q[AW-1:4] == (AW-4)'(POP_ROW_B));
    assign addr_inc   = romwr_a_q + AW'(2);
    assign unused_idx = ^ioctl_index[7:5];

    always_comb begin
        state_d     = state_q;
        rom_wr_d    = rom_wr_q;
        wait_d      = wait_q;
        romwr_a_d   = romwr_a_q;
        romwr_d_d   = romwr_d_q;
        sgx_d       = sgx_q;
        populous_d  = populous_q;
        hdr_d       = hdr_q;
        ovf_d       = ovf_q;
        fall_pend_d = fall_pend_q;

        if (ioctl_wr && ioctl_download && (state_q != ST_READY)) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A new download overrides any strobe in the same cycle
                if (dl_rise) begin
                    state_d     = ST_READY;
                    romwr_a_d   = '0;
                    populous_d  = 2'b11;
                    ovf_d       = 1'b0;
                    fall_pend_d = 1'b0;
                    sgx_d       = (ioctl_index[4:0] == SGX_INDEX);
                end
            end
            ST_READY: begin
                if (dl_fall) begin
                    state_d = ST_DONE;
                    hdr_d   = romwr_a_q[9];
                end else if (ioctl_wr) begin
                    romwr_d_d = wr_data;
                    rom_wr_d  = ~rom_wr_q;
                    wait_d    = 1'b1;
                    state_d   = ST_ACK;
                    if (pop_row && sig[16] && (wr_data != sig[15:0])) begin
                        populous_d[romwr_a_q[13]] = 1'b0;
                    end
                end
            end
            ST_ACK: begin
                if (dl_fall) begin
                    fall_pend_d = 1'b1;
                end
                // The word in flight must complete before the download can close
                if (acked) begin
                    wait_d      = 1'b0;
                    romwr_a_d   = addr_inc;
                    fall_pend_d = 1'b0;
                    if (fall_pend_q || dl_fall) begin
                        state_d = ST_DONE;
                        hdr_d   = addr_inc[9];
                    end else begin
                        state_d = ST_READY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        dl_q <= ioctl_download;
        if (reset) begin
            state_q     <= ST_IDLE;
            wait_q      <= 1'b0;
            ovf_q       <= 1'b0;
            fall_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_wr_q    <= rom_wr_d;
            wait_q      <= wait_d;
            romwr_a_q   <= romwr_a_d;
            romwr_d_q   <= romwr_d_d;
            sgx_q       <= sgx_d;
            populous_q  <= populous_d;
            hdr_q       <= hdr_d;
            ovf_q       <= ovf_d;
            fall_pend_q <= fall_pend_d;
        end
    end

    assign ioctl_wait = wait_q;
    assign romwr_a    = romwr_a_q;
    assign romwr_d    = romwr_d_q;
    assign rom_wr     = rom_wr_q;
    assign sgx        = sgx_q;
    assign populous   = populous_q;
    assign hdr        = hdr_q;
    assign rom_sz     = romwr_a_q[AW-1:16];
    assign ovf        = ovf_q;

endmodule
